// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a scanned 7-segment bus: filters scan transitions, decodes digits, reports frames.
// Optional build macro SEG7_SCAN_DP_CAPTURE_EN enables per-digit decimal-point capture.
module seg7_scan_decoder #(
   parameter int NUM_DIG     = 8,
   parameter int STABLE_CYC  = 4,
   parameter int SEL_ACT_LOW = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_DIG-1:0]     seg7_sel,
   input  logic [7:0]             seg7,
   output logic [4*NUM_DIG-1:0]   digits,
   output logic [NUM_DIG-1:0]     digit_ok,
   output logic [NUM_DIG-1:0]     digit_blank,
   output logic [NUM_DIG-1:0]     dp,
   output logic                   frame_done,
   output logic [15:0]            frame_cnt,
   output logic                   pat_err,
   output logic                   sel_err
);

   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYC);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYC - 1);

   logic [NUM_DIG-1:0] sel_r, sel_p, sel_n, seen, seen_nxt;
   logic [7:0]         seg_r, seg_p, seg_n;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic               captured, same, cap, sel_one, upd;
   logic [4:0]         dec;

   function automatic logic [4:0] seg_decode(input logic [6:0] p);
      case (p)
         7'h3F: return 5'h10;
         7'h06: return 5'h11;
         7'h5B: return 5'h12;
         7'h4F: return 5'h13;
         7'h66: return 5'h14;
         7'h6D: return 5'h15;
         7'h7D: return 5'h16;
         7'h07: return 5'h17;
         7'h7F: return 5'h18;
         7'h6F: return 5'h19;
         7'h77: return 5'h1A;
         7'h7C: return 5'h1B;
         7'h39: return 5'h1C;
         7'h5E: return 5'h1D;
         7'h79: return 5'h1E;
         7'h71: return 5'h1F;
         default: return 5'h00;
      endcase
   endfunction

   // Normalise to active-high; without dp capture bit 7 never reaches the stability compare.
   always_comb begin
      sel_n = (SEL_ACT_LOW != 0) ? ~sel_r : sel_r;
      seg_n = (SEG_ACT_LOW != 0) ? ~seg_r : seg_r;
`ifndef SEG7_SCAN_DP_CAPTURE_EN
      seg_n[7] = 1'b0;
`endif
   end

   assign same     = (sel_n == sel_p) && (seg_n == seg_p);
   assign cnt_nxt  = !same ? '0 : (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
   assign cap      = same && !captured && (cnt_nxt >= CNT_CAP);
   assign sel_one  = (sel_n != '0) && ((sel_n & (sel_n - NUM_DIG'(1))) == '0);
   assign upd      = cap && sel_one;
   assign seen_nxt = seen | sel_n;
   assign dec      = seg_decode(seg_n[6:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_r    <= '0;
         seg_r    <= '0;
         sel_p    <= '0;
         seg_p    <= '0;
         cnt      <= '0;
         captured <= 1'b0;
      end else begin
         sel_r    <= seg7_sel;
         seg_r    <= seg7;
         sel_p    <= sel_n;
         seg_p    <= seg_n;
         cnt      <= cnt_nxt;
         captured <= same && (captured || cap);
      end
   end

   // Per-digit capture; an illegal pattern keeps the previous nibble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits      <= '0;
         digit_ok    <= '0;
         digit_blank <= '0;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
         dp          <= '0;
`endif
      end else if (upd) begin
         for (int i = 0; i < NUM_DIG; i++) begin
            if (sel_n[i]) begin
               if (seg_n[6:0] == 7'h00) begin
                  digits[4*i +: 4] <= 4'h0;
                  digit_ok[i]      <= 1'b0;
                  digit_blank[i]   <= 1'b1;
               end else if (dec[4]) begin
                  digits[4*i +: 4] <= dec[3:0];
                  digit_ok[i]      <= 1'b1;
                  digit_blank[i]   <= 1'b0;
               end else begin
                  digit_ok[i]      <= 1'b0;
                  digit_blank[i]   <= 1'b0;
               end
`ifdef SEG7_SCAN_DP_CAPTURE_EN
               dp[i] <= seg_n[7];
`endif
            end
         end
      end
   end

`ifndef SEG7_SCAN_DP_CAPTURE_EN
   assign dp = '0;
`endif

   // The completing capture belongs to the finished frame, so seen restarts empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen       <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         pat_err    <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         pat_err    <= 1'b0;
         sel_err    <= cap && !sel_one && (sel_n != '0);
         if (upd) begin
            pat_err <= (seg_n[6:0] != 7'h00) && !dec[4];
            if (&seen_nxt) begin
               frame_done <= 1'b1;
               seen       <= '0;
               frame_cnt  <= frame_cnt + 16'd1;
            end else begin
               seen <= seen_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised bench for seg7_scan_decoder against a dwell-length reference model.
// Build with +define+SEG7_SCAN_DP_CAPTURE_EN to cover the dp feature.
module tb_seg7_scan_decoder;

   localparam int ND = 8;
   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  seg7_sel, seg7;
   logic [31:0] digits;
   logic [7:0]  digit_ok, digit_blank, dp;
   logic        frame_done, pat_err, sel_err;
   logic [15:0] frame_cnt;

   seg7_scan_decoder #(.NUM_DIG(ND), .STABLE_CYC(SC), .SEL_ACT_LOW(1), .SEG_ACT_LOW(1)) dut (
      .clk(clk), .rst_n(rst_n), .seg7_sel(seg7_sel), .seg7(seg7),
      .digits(digits), .digit_ok(digit_ok), .digit_blank(digit_blank), .dp(dp),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .pat_err(pat_err), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a pair held for SC sampled cycles is captured once, one edge later.
   logic [6:0]  pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [31:0] m_dig;
   logic [7:0]  m_ok, m_blank, m_dp, m_seen, p_sel, p_seg;
   logic        m_fd, m_pe, m_se, pend, key_valid;
   logic [15:0] m_cnt, last_key;
   int          run;

   function automatic int find_pat(input logic [6:0] g);
      for (int n = 0; n < 16; n++) if (pats[n] == g) return n;
      return -1;
   endfunction

   task automatic model_reset();
      m_dig = '0; m_ok = '0; m_blank = '0; m_dp = '0; m_seen = '0;
      m_fd = 0; m_pe = 0; m_se = 0; m_cnt = '0;
      pend = 0; key_valid = 0; run = 0; last_key = '0;
   endtask

   task automatic model_capture(input logic [7:0] s, input logic [7:0] g);
      int idx, f;
      if (s == 8'h00) return;
      if ($countones(s) != 1) begin m_se = 1; return; end
      idx = 0;
      for (int i = 0; i < ND; i++) if (s[i]) idx = i;
      f = find_pat(g[6:0]);
      if (g[6:0] == 7'h00) begin
         m_dig[4*idx +: 4] = 4'h0; m_ok[idx] = 0; m_blank[idx] = 1;
      end else if (f >= 0) begin
         m_dig[4*idx +: 4] = 4'(f); m_ok[idx] = 1; m_blank[idx] = 0;
      end else begin
         m_ok[idx] = 0; m_blank[idx] = 0; m_pe = 1;
      end
`ifdef SEG7_SCAN_DP_CAPTURE_EN
      m_dp[idx] = g[7];
`endif
      m_seen[idx] = 1;
      if (&m_seen) begin m_fd = 1; m_seen = '0; m_cnt++; end
   endtask

   task automatic check_all();
      chk("digits", 64'(digits), 64'(m_dig));
      chk("ok", 64'(digit_ok), 64'(m_ok));
      chk("blank", 64'(digit_blank), 64'(m_blank));
      chk("dp", 64'(dp), 64'(m_dp));
      chk("frame_done", 64'(frame_done), 64'(m_fd));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
      chk("pat_err", 64'(pat_err), 64'(m_pe));
      chk("sel_err", 64'(sel_err), 64'(m_se));
   endtask

   // One clock with active-high select s and segments g driven onto the active-low bus.
   task automatic cycle(input logic [7:0] s, input logic [7:0] g);
      logic [15:0] key;
      check_all();
      seg7_sel = ~s;
      seg7     = ~g;
      m_fd = 0; m_pe = 0; m_se = 0;
      if (pend) model_capture(p_sel, p_seg);
      pend = 0;
`ifdef SEG7_SCAN_DP_CAPTURE_EN
      key = {s, g};
`else
      key = {s, 1'b0, g[6:0]};
`endif
      if (key_valid && key == last_key) begin
         if (run <= SC) run++;
      end else run = 1;
      last_key  = key;
      key_valid = 1;
      if (run == SC) begin pend = 1; p_sel = s; p_seg = key[7:0]; end
      @(negedge clk);
   endtask

   task automatic hold(input logic [7:0] s, input logic [7:0] g, input int n);
      for (int k = 0; k < n; k++) cycle(s, g);
   endtask

   logic seen_pulse;

   initial begin
      seg7_sel = 8'hFF;
      seg7     = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_digits", 64'(digits), 64'd0);
      chk("rst_ok", 64'(digit_ok), 64'd0);
      chk("rst_blank", 64'(digit_blank), 64'd0);
      chk("rst_cnt", 64'(frame_cnt), 64'd0);
      rst_n = 1'b1;
      hold(8'h00, 8'h00, 3);

      // capture latency: nothing after 4 edges, digit 0 after the 5th
      hold(8'h01, 8'h3F, 4);
      chk("t2_pre_ok0", 64'(digit_ok[0]), 64'd0);
      hold(8'h01, 8'h3F, 2);
      chk("t2_ok0", 64'(digit_ok[0]), 64'd1);
      chk("t2_dig0", 64'(digits[3:0]), 64'd0);

      // short dwell is filtered
      hold(8'h02, 8'h06, 3);
      hold(8'h00, 8'h00, 6);
      chk("t3_ok1", 64'(digit_ok[1]), 64'd0);

      // full scan with 1-clk gaps
      for (int d = 0; d < 8; d++) begin
         hold(8'(1 << d), {1'b0, pats[d+1]}, 8);
         hold(8'h00, 8'h00, 1);
      end
      hold(8'h00, 8'h00, 4);
      chk("t4_digits", 64'(digits), 64'h87654321);
      chk("t4_ok", 64'(digit_ok), 64'hFF);
      chk("t4_cnt", 64'(frame_cnt), 64'd1);

      // illegal pattern keeps nibble
      hold(8'h04, 8'h6D, 6);
      chk("t5_dig2", 64'(digits[11:8]), 64'd5);
      seen_pulse = 0;
      for (int k = 0; k < 6; k++) begin cycle(8'h04, 8'h49); seen_pulse |= pat_err; end
      chk("t5_pat_err", 64'(seen_pulse), 64'd1);
      chk("t5_ok2", 64'(digit_ok[2]), 64'd0);
      chk("t5_dig2_keep", 64'(digits[11:8]), 64'd5);

      // multi-hot select
      seen_pulse = 0;
      for (int k = 0; k < 6; k++) begin cycle(8'h03, 8'h3F); seen_pulse |= sel_err; end
      chk("t6_sel_err", 64'(seen_pulse), 64'd1);
      chk("t6_digits", 64'(digits), 64'h87654521);

      // blank digit
      hold(8'h10, 8'h00, 6);
      chk("blank4", 64'(digit_blank[4]), 64'd1);
      chk("blank4_nib", 64'(digits[19:16]), 64'd0);

`ifdef SEG7_SCAN_DP_CAPTURE_EN
      hold(8'h01, 8'hBF, 6);
      chk("dp0", 64'(dp[0]), 64'd1);
      chk("dp_dig0", 64'(digits[3:0]), 64'd0);
`endif

      // reset mid-dwell clears immediately
      hold(8'h08, 8'h4F, 2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("mrst_digits", 64'(digits), 64'd0);
      chk("mrst_cnt", 64'(frame_cnt), 64'd0);
      chk("mrst_ok", 64'(digit_ok), 64'd0);
      seg7_sel = 8'hFF;
      seg7     = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // randomised dwells
      for (int n = 0; n < 450; n++) begin
         logic [7:0] s, g;
         int r;
         r = $urandom_range(0, 9);
         if (r == 0) s = 8'h00;
         else if (r == 1) s = 8'($urandom) | 8'h81;
         else s = 8'(1 << $urandom_range(0, 7));
         r = $urandom_range(0, 9);
         if (r == 0) g = 8'h00;
         else if (r == 1) g = {1'b0, 7'($urandom)};
         else g = {1'b0, pats[$urandom_range(0, 15)]};
         g[7] = 1'($urandom);
         hold(s, g, $urandom_range(1, 8));
      end
      hold(8'h00, 8'h00, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
